sfp_link_ctrl: RTL and testbench
================================

// Module: sfp_link_ctrl
// PURPOSE
//  Link sequencer for the 60MHz SFP serial TX path. Gates SFP TX enable/driver, schedules
//  K28.5 lock-symbol bursts vs data frames, recovers from SFP TX faults with bounded retries.
//  Frame-synchronous: drives the TX serializer's lock-symbol select and owns SFP TX_DISABLE.
// PARAMETERS
//  FRAME_DIV      30    clocks per frame (60MHz / 2Mbps)
//  EN_WAIT_FRM    16    frames between SFP TX enable and driver enable
//  SYNC_BURST     5     consecutive K28.5 frames per burst
//  DATA_GAP       5     data frames after each burst
//  LOCK_TIMEOUT   2000  frames in ALIGN without lock before fault retry
//  FLT_HOLD       200   consecutive fault-free frames required to leave FAULT
//  FLT_RETRY_MAX  3     retries before LOCKOUT
// PORTS
//  i_clk            in   1  60MHz clock
//  i_res            in   1  synchronous reset, active high
//  i_enable         in   1  link enable request (level)
//  i_sfp_tx_flt     in   1  SFP TX_FAULT, active high
//  i_my_lock        in   1  local receiver locked
//  i_rx_lock        in   1  lock bit from far-end frame
//  o_frame_tick     out  1  1-clk pulse, last clock of each frame
//  o_k28_5_send_en  out  1  1 = current frame is K28.5, 0 = data
//  o_sfp_tx_dis     out  1  SFP TX_DISABLE, active high
//  o_drv_en         out  1  line driver enable
//  o_link_up        out  1  state == RUN
//  o_state          out  3  OFF=0 WAIT=1 ALIGN=2 RUN=3 FAULT=4 LOCKOUT=5
//  o_retry_cnt      out  2+ fault retries used ($clog2(FLT_RETRY_MAX+1) bits)
// BEHAVIOUR
//  Reset: state OFF, frame cnt 0, all counters 0; o_sfp_tx_dis=1, all other outputs 0.
//  Frame prescaler: free-running 0..FRAME_DIV-1; o_frame_tick = (cnt==FRAME_DIV-1).
//  "At tick" = registered on the edge ending a tick cycle; new value visible next clock.
//  Priority each clock: i_res > ~i_enable (->OFF, retry_cnt=0) > fault entry > tick transitions.
//  OFF: tx_dis=1, drv_en=0. At tick with i_enable -> WAIT, frm_cnt=0.
//  WAIT: tx_dis=0, drv_en=0. Count ticks; at EN_WAIT_FRM-th tick -> ALIGN, phase=0, tmo=0.
//  ALIGN: drv_en=1. Phase counter 0..SYNC_BURST+DATA_GAP-1 advances at tick, wraps;
//   k28_5_send_en = (phase < SYNC_BURST). At tick where phase==last and my_lock&rx_lock -> RUN.
//   tmo increments at tick; at LOCK_TIMEOUT-th tick without exit -> FAULT (counts as retry).
//  RUN: k28_5_send_en=0, link_up=1, retry_cnt cleared on entry. At tick with
//   ~my_lock|~rx_lock -> ALIGN, phase=0 (burst starts next frame), tmo=0.
//  FAULT: tx_dis=1, drv_en=0, k=0. hold cnt cleared on any clock with i_sfp_tx_flt=1,
//   else increments at tick. At FLT_HOLD: retry_cnt<FLT_RETRY_MAX -> WAIT, retry_cnt+1;
//   else -> LOCKOUT.
//  LOCKOUT: tx_dis=1, drv_en=0; exits only via ~i_enable (-> OFF).
//  Fault entry: i_sfp_tx_flt=1 in WAIT/ALIGN/RUN -> FAULT next clock, no tick wait.
//   o_drv_en = drv_en_reg & ~i_sfp_tx_flt (zero-latency cutoff, only comb. path).
//  Fault and tick same clock: fault wins. Fault and ~i_enable same clock: OFF wins.
//  retry_cnt saturates at FLT_RETRY_MAX. k28_5_send_en changes only at tick (frame aligned).
// TESTING (FRAME_DIV=4 EN_WAIT_FRM=2 SYNC_BURST=2 DATA_GAP=2 LOCK_TIMEOUT=20 FLT_HOLD=3 FLT_RETRY_MAX=2)
//  Reset then enable=1, locks=1 -> OFF->WAIT at first tick, ALIGN after 2 ticks; k=1,1,0,0;
//   RUN after 4th ALIGN tick; link_up=1; tick period exactly 4 clocks.
//  In RUN drop rx_lock for 1 clk spanning tick -> ALIGN next clk, k=1 for 2 frames, relock ->
//   RUN after 4 frames.
//  Locks held 0 in ALIGN -> FAULT after 20 ticks, retry_cnt=1, tx_dis=1; WAIT after 3 ticks.
//  flt=1 mid-frame in RUN -> o_drv_en=0 same clk, state=FAULT next clk; flt pulsed again
//   after 2 fault-free ticks -> hold restarts, exit needs 3 more ticks.
//  Three faults without reaching RUN -> LOCKOUT; stays despite locks=1;
//   enable=0 -> OFF, retry_cnt=0.
//  Assert i_res mid-ALIGN and mid-FAULT -> next clk all outputs at reset values, cnt=0.

Source files
------------

// File: rtl/sfp_link_ctrl.sv
// Link sequencer for the SFP serial TX path: gates TX_DISABLE and the line driver,
// interleaves K28.5 lock bursts with data frames, and recovers from TX faults with bounded retries.
module sfp_link_ctrl #(
    parameter int FRAME_DIV     = 30,
    parameter int EN_WAIT_FRM   = 16,
    parameter int SYNC_BURST    = 5,
    parameter int DATA_GAP      = 5,
    parameter int LOCK_TIMEOUT  = 2000,
    parameter int FLT_HOLD      = 200,
    parameter int FLT_RETRY_MAX = 3
) (
    input  logic                                 i_clk,
    input  logic                                 i_res,
    input  logic                                 i_enable,
    input  logic                                 i_sfp_tx_flt,
    input  logic                                 i_my_lock,
    input  logic                                 i_rx_lock,
    output logic                                 o_frame_tick,
    output logic                                 o_k28_5_send_en,
    output logic                                 o_sfp_tx_dis,
    output logic                                 o_drv_en,
    output logic                                 o_link_up,
    output logic [2:0]                           o_state,
    output logic [$clog2(FLT_RETRY_MAX+1)-1:0]   o_retry_cnt
);

    localparam int PHASES = SYNC_BURST + DATA_GAP;
    localparam int FW = (FRAME_DIV    > 1) ? $clog2(FRAME_DIV)    : 1;
    localparam int EW = (EN_WAIT_FRM  > 1) ? $clog2(EN_WAIT_FRM)  : 1;
    localparam int PW = (PHASES       > 1) ? $clog2(PHASES)       : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int HW = (FLT_HOLD     > 1) ? $clog2(FLT_HOLD)     : 1;
    localparam int RW = $clog2(FLT_RETRY_MAX + 1);

    localparam logic [FW-1:0] FD_LAST   = FW'(FRAME_DIV - 1);
    localparam logic [EW-1:0] EW_LAST   = EW'(EN_WAIT_FRM - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(PHASES - 1);
    localparam logic [PW-1:0] PH_BURST  = PW'(SYNC_BURST);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(FLT_HOLD - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(FLT_RETRY_MAX);

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_ALIGN   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    logic [FW-1:0] fcnt_q,  fcnt_d;
    logic [2:0]    state_q, state_d;
    logic [EW-1:0] wait_q,  wait_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          tx_dis_q, tx_dis_d;
    logic          drv_en_q, drv_en_d;
    logic          k_q,      k_d;
    logic          link_q,   link_d;
    logic          tick_s;
    logic          locked_s;
    logic          flt_entry_s;

    assign tick_s      = (fcnt_q == FD_LAST);
    assign locked_s    = i_my_lock & i_rx_lock;
    assign flt_entry_s = i_sfp_tx_flt &
                         ((state_q == ST_WAIT) || (state_q == ST_ALIGN) || (state_q == ST_RUN));

    // Free-running frame prescaler.
    always_comb begin
        if (tick_s) begin
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    // Sequencer next state: disable beats fault entry, fault entry beats tick-driven moves.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        phase_d = phase_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        retry_d = retry_q;
        if (!i_enable) begin
            state_d = ST_OFF;
            retry_d = '0;
            wait_d  = '0;
            phase_d = '0;
            tmo_d   = '0;
            hold_d  = '0;
        end else if (flt_entry_s) begin
            state_d = ST_FAULT;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (tick_s) begin
                        state_d = ST_WAIT;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_WAIT: begin
                    if (tick_s && (wait_q == EW_LAST)) begin
                        state_d = ST_ALIGN;
                        phase_d = '0;
                        tmo_d   = '0;
                    end else if (tick_s) begin
                        wait_d = wait_q + EW'(1);
                    end else begin
                        wait_d = wait_q;
                    end
                end
                ST_ALIGN: begin
                    if (tick_s && (phase_q == PH_LAST) && locked_s) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (tick_s) begin
                        phase_d = (phase_q == PH_LAST) ? '0 : (phase_q + PW'(1));
                        if (tmo_q == TMO_LAST) begin
                            state_d = ST_FAULT;
                            hold_d  = '0;
                        end else begin
                            tmo_d = tmo_q + TW'(1);
                        end
                    end else begin
                        phase_d = phase_q;
                    end
                end
                ST_RUN: begin
                    if (tick_s && !locked_s) begin
                        state_d = ST_ALIGN;
                        phase_d = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    if (i_sfp_tx_flt) begin
                        hold_d = '0;
                    end else if (tick_s && (hold_q == HOLD_LAST)) begin
                        hold_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            state_d = ST_WAIT;
                            wait_d  = '0;
                            retry_d = retry_q + RW'(1);
                        end else begin
                            state_d = ST_LOCKOUT;
                        end
                    end else if (tick_s) begin
                        hold_d = hold_q + HW'(1);
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_LOCKOUT: begin
                    state_d = ST_LOCKOUT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        tx_dis_d = 1'b1;
        drv_en_d = 1'b0;
        k_d      = 1'b0;
        link_d   = 1'b0;
        case (state_d)
            ST_WAIT: begin
                tx_dis_d = 1'b0;
            end
            ST_ALIGN: begin
                tx_dis_d = 1'b0;
                drv_en_d = 1'b1;
                k_d      = (phase_d < PH_BURST);
            end
            ST_RUN: begin
                tx_dis_d = 1'b0;
                drv_en_d = 1'b1;
                link_d   = 1'b1;
            end
            default: begin
                tx_dis_d = 1'b1;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            fcnt_q   <= '0;
            state_q  <= ST_OFF;
            wait_q   <= '0;
            phase_q  <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
            retry_q  <= '0;
            tx_dis_q <= 1'b1;
            drv_en_q <= 1'b0;
            k_q      <= 1'b0;
            link_q   <= 1'b0;
        end else begin
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            wait_q   <= wait_d;
            phase_q  <= phase_d;
            tmo_q    <= tmo_d;
            hold_q   <= hold_d;
            retry_q  <= retry_d;
            tx_dis_q <= tx_dis_d;
            drv_en_q <= drv_en_d;
            k_q      <= k_d;
            link_q   <= link_d;
        end
    end

    // The fault input cuts the driver combinationally, without waiting for the state change.
    assign o_drv_en        = drv_en_q & ~i_sfp_tx_flt;
    assign o_frame_tick    = tick_s;
    assign o_k28_5_send_en = k_q;
    assign o_sfp_tx_dis    = tx_dis_q;
    assign o_link_up       = link_q;
    assign o_state         = state_q;
    assign o_retry_cnt     = retry_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed bench for sfp_link_ctrl with small parameters; each check is an immediate assertion.
module tb_sfp_link_ctrl;

    logic       clk;
    logic       res;
    logic       enable;
    logic       flt;
    logic       my_lock;
    logic       rx_lock;
    logic       frame_tick;
    logic       k_en;
    logic       tx_dis;
    logic       drv_en;
    logic       link_up;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int nclk;

    sfp_link_ctrl #(
        .FRAME_DIV(4), .EN_WAIT_FRM(2), .SYNC_BURST(2), .DATA_GAP(2),
        .LOCK_TIMEOUT(20), .FLT_HOLD(3), .FLT_RETRY_MAX(2)
    ) dut (
        .i_clk(clk), .i_res(res), .i_enable(enable), .i_sfp_tx_flt(flt),
        .i_my_lock(my_lock), .i_rx_lock(rx_lock), .o_frame_tick(frame_tick),
        .o_k28_5_send_en(k_en), .o_sfp_tx_dis(tx_dis), .o_drv_en(drv_en),
        .o_link_up(link_up), .o_state(state), .o_retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run until the frame tick is seen, then cross the edge that ends it.
    task automatic next_frame(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!seen) begin
                step();
                n++;
                if (frame_tick === 1'b1) seen = 1'b1;
            end
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
        step();
        n++;
    endtask

    task automatic frames(input int cnt);
        for (int i = 0; i < cnt; i++) next_frame(nclk);
    endtask

    initial begin
        res = 1'b1; enable = 1'b0; flt = 1'b0; my_lock = 1'b0; rx_lock = 1'b0;
        step(); step();
        res = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_tx_dis", 32'(tx_dis), 32'd1);
        check("rst_drv_en", 32'(drv_en), 32'd0);
        check("rst_k", 32'(k_en), 32'd0);
        check("rst_link", 32'(link_up), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);

        // Bring-up with locks held
        enable = 1'b1; my_lock = 1'b1; rx_lock = 1'b1;
        next_frame(nclk);
        check("first_tick_clks", 32'(nclk), 32'd4);
        check("wait_state", 32'(state), 32'd1);
        check("wait_tx_dis", 32'(tx_dis), 32'd0);
        check("wait_drv_en", 32'(drv_en), 32'd0);
        next_frame(nclk);
        check("wait_hold", 32'(state), 32'd1);
        next_frame(nclk);
        check("align_state", 32'(state), 32'd2);
        check("align_k0", 32'(k_en), 32'd1);
        check("align_drv_en", 32'(drv_en), 32'd1);
        next_frame(nclk);
        check("align_k1", 32'(k_en), 32'd1);
        next_frame(nclk);
        check("align_k2", 32'(k_en), 32'd0);
        next_frame(nclk);
        check("align_k3", 32'(k_en), 32'd0);
        check("align_still", 32'(state), 32'd2);
        next_frame(nclk);
        check("run_state", 32'(state), 32'd3);
        check("run_link", 32'(link_up), 32'd1);
        check("run_k", 32'(k_en), 32'd0);
        check("frame_period", 32'(nclk), 32'd4);

        // One-clock rx_lock drop across the tick
        step(); step(); step();
        check("tick_at_cnt3", 32'(frame_tick), 32'd1);
        rx_lock = 1'b0;
        step();
        rx_lock = 1'b1;
        check("relock_align", 32'(state), 32'd2);
        check("relock_k", 32'(k_en), 32'd1);
        next_frame(nclk);
        check("relock_k1", 32'(k_en), 32'd1);
        next_frame(nclk);
        check("relock_k2", 32'(k_en), 32'd0);
        next_frame(nclk);
        check("relock_not_yet", 32'(state), 32'd2);
        next_frame(nclk);
        check("relock_run", 32'(state), 32'd3);

        // Fault mid-frame in RUN, then a re-pulse restarting the hold
        step();
        flt = 1'b1;
        #1;
        check("flt_drv_cut", 32'(drv_en), 32'd0);
        check("flt_same_clk_state", 32'(state), 32'd3);
        step();
        flt = 1'b0;
        check("flt_state", 32'(state), 32'd4);
        check("flt_tx_dis", 32'(tx_dis), 32'd1);
        check("flt_link", 32'(link_up), 32'd0);
        frames(2);
        check("flt_hold2", 32'(state), 32'd4);
        flt = 1'b1;
        step();
        flt = 1'b0;
        frames(2);
        check("flt_restart", 32'(state), 32'd4);
        next_frame(nclk);
        check("flt_exit_wait", 32'(state), 32'd1);
        check("flt_retry1", 32'(retry_cnt), 32'd1);

        // Lock timeout in ALIGN
        my_lock = 1'b0; rx_lock = 1'b0;
        frames(2);
        check("tmo_align", 32'(state), 32'd2);
        frames(19);
        check("tmo_not_yet", 32'(state), 32'd2);
        next_frame(nclk);
        check("tmo_fault", 32'(state), 32'd4);
        check("tmo_retry", 32'(retry_cnt), 32'd1);
        check("tmo_tx_dis", 32'(tx_dis), 32'd1);
        frames(3);
        check("tmo_wait", 32'(state), 32'd1);
        check("tmo_retry2", 32'(retry_cnt), 32'd2);

        // Third fault without RUN -> LOCKOUT
        flt = 1'b1;
        step();
        flt = 1'b0;
        check("f3_fault", 32'(state), 32'd4);
        frames(3);
        check("lockout", 32'(state), 32'd5);
        check("lockout_retry", 32'(retry_cnt), 32'd2);
        my_lock = 1'b1; rx_lock = 1'b1;
        frames(2);
        check("lockout_stays", 32'(state), 32'd5);
        check("lockout_tx_dis", 32'(tx_dis), 32'd1);
        enable = 1'b0;
        step();
        check("off_state", 32'(state), 32'd0);
        check("off_retry", 32'(retry_cnt), 32'd0);

        // Reset mid-ALIGN
        enable = 1'b1; my_lock = 1'b0; rx_lock = 1'b0;
        frames(3);
        check("pre_rst_align", 32'(state), 32'd2);
        step();
        res = 1'b1;
        step();
        res = 1'b0;
        check("rstA_state", 32'(state), 32'd0);
        check("rstA_k", 32'(k_en), 32'd0);
        check("rstA_drv", 32'(drv_en), 32'd0);
        check("rstA_tx_dis", 32'(tx_dis), 32'd1);
        next_frame(nclk);
        check("rstA_cnt0", 32'(nclk), 32'd4);
        check("rstA_wait", 32'(state), 32'd1);

        // Reset mid-FAULT
        flt = 1'b1;
        step();
        check("pre_rst_fault", 32'(state), 32'd4);
        step();
        res = 1'b1;
        step();
        res = 1'b0; flt = 1'b0;
        check("rstF_state", 32'(state), 32'd0);
        check("rstF_tx_dis", 32'(tx_dis), 32'd1);
        check("rstF_tick", 32'(frame_tick), 32'd0);
        next_frame(nclk);
        check("rstF_cnt0", 32'(nclk), 32'd4);

        // Fault and disable on the same clock: OFF wins
        check("pre_both_wait", 32'(state), 32'd1);
        flt = 1'b1; enable = 1'b0;
        step();
        check("both_off", 32'(state), 32'd0);
        check("both_tx_dis", 32'(tx_dis), 32'd1);
        flt = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
